// File: rtl/icc_branch_unit_if.sv
// Branch handshake between the decode stage (master) and icc_branch_unit (slave).
interface icc_branch_unit_if;
  logic       br_valid;
  logic [3:0] cond;
  logic       annul;
  logic       br_ready;

  modport master (output br_valid, output cond, output annul, input  br_ready);
  modport slave  (input  br_valid, input  cond, input  annul, output br_ready);
endinterface

// File: rtl/icc_branch_unit.sv
// Integer condition-code register plus SPARC Bicc resolution with a
// delay-slot/annul FSM and a one-cycle fetch redirect for taken branches.
module icc_branch_unit #(
  parameter int unsigned CNT_W     = 16,
  parameter logic [3:0]  ICC_RESET = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icc_we,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              v_in,
  input  logic              c_in,
  icc_branch_unit_if.slave  br,
  input  logic              slot_done,
  input  logic              flush,
  output logic [3:0]        icc,
  output logic              taken,
  output logic              annul_slot,
  output logic              redirect,
  output logic [CNT_W-1:0]  taken_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSLOT = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       icc_q, icc_d;
  logic             taken_q, taken_d;
  logic             annul_q, annul_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] flags_eval;
  logic       cond_true;
  logic       accept;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'b1000: eval_cond = 1'b1;
      4'b0000: eval_cond = 1'b0;
      4'b1001: eval_cond = ~z;
      4'b0001: eval_cond = z;
      4'b1010: eval_cond = ~(z | (n ^ v));
      4'b0010: eval_cond = z | (n ^ v);
      4'b1011: eval_cond = ~(n ^ v);
      4'b0011: eval_cond = n ^ v;
      4'b1100: eval_cond = ~(cy | z);
      4'b0100: eval_cond = cy | z;
      4'b1101: eval_cond = ~cy;
      4'b0101: eval_cond = cy;
      4'b1110: eval_cond = ~n;
      4'b0110: eval_cond = n;
      4'b1111: eval_cond = ~v;
      default: eval_cond = v;
    endcase
  endfunction

  // Flags retiring in the acceptance cycle are bypassed into the evaluation.
  assign flags_eval = icc_we ? {n_in, z_in, v_in, c_in} : icc_q;
  assign cond_true  = eval_cond(br.cond, flags_eval);
  assign br.br_ready = (state_q == IDLE);
  assign accept     = br.br_valid & br.br_ready & ~flush;

  always_comb begin
    icc_d = icc_q;
    if (icc_we) icc_d = {n_in, z_in, v_in, c_in};
  end

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    annul_d = annul_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      taken_d = 1'b0;
      annul_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = DSLOT;
            taken_d = cond_true;
            annul_d = br.annul & (~cond_true | (br.cond == 4'b1000));
            if (cond_true) cnt_d = cnt_q + 1'b1;
          end
        end
        DSLOT: begin
          if (slot_done) begin
            if (taken_q) begin
              state_d = REDIR;
            end else begin
              state_d = IDLE;
              taken_d = 1'b0;
              annul_d = 1'b0;
            end
          end
        end
        REDIR: begin
          state_d = IDLE;
          taken_d = 1'b0;
          annul_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          taken_d = 1'b0;
          annul_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      icc_q   <= ICC_RESET;
      taken_q <= 1'b0;
      annul_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      icc_q   <= icc_d;
      taken_q <= taken_d;
      annul_q <= annul_d;
      cnt_q   <= cnt_d;
    end
  end

  assign icc        = icc_q;
  assign taken      = taken_q;
  assign annul_slot = annul_q;
  assign redirect   = (state_q == REDIR);
  assign taken_cnt  = cnt_q;

endmodule
